// File: rtl/seq_detector_param.sv
// Programmable serial bit-pattern detector with runtime pattern/length/overlap and a Mealy match flag.
// Optional saturating match counter is built only when MATCH_CNT_EN is defined.
module seq_detector_param #(
    parameter int unsigned        MAX_LEN     = 8,
    parameter int unsigned        LEN_W       = $clog2(MAX_LEN) + 1,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(2'b11),
    parameter int unsigned        DEF_LEN     = 2,
    parameter bit                 DEF_OVL     = 1'b1,
    parameter int unsigned        CNT_W       = 8
) (
    input  logic               clk,
    input  logic               rst_b,
    input  logic               en,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               x_vld,
    input  logic               x,
    output logic               y,
    input  logic               cnt_clr,
    output logic [CNT_W-1:0]   match_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_HUNT = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [MAX_LEN-1:0]   hist_q, hist_d;
    logic [LEN_W-1:0]     fill_q, fill_d;
    logic [MAX_LEN-1:0]   pattern_q;
    logic [LEN_W-1:0]     len_q;
    logic                 ovl_q;

    logic                 cfg_we;
    logic [LEN_W-1:0]     cfg_len_clamped;
    logic [LEN_W-1:0]     len_eff;
    logic                 accept;
    logic [MAX_LEN-1:0]   hist_n;
    logic [LEN_W-1:0]     fill_n;
    logic [MAX_LEN-1:0]   len_mask;
    logic                 hit;
    logic                 unused_hist_msb;

    // Config is only writable while the detector is parked in IDLE.
    assign cfg_we  = cfg_load && (state_q == S_IDLE);
    assign len_eff = cfg_we ? cfg_len_clamped : len_q;
    assign accept  = en && x_vld && (state_q != S_IDLE);
    assign hist_n  = {hist_q[MAX_LEN-2:0], x};
    assign fill_n  = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);
    assign unused_hist_msb = hist_q[MAX_LEN-1];

    always_comb begin
        cfg_len_clamped = cfg_len;
        if (cfg_len == '0) begin
            cfg_len_clamped = LEN_W'(1);
        end else if (cfg_len > LEN_W'(MAX_LEN)) begin
            cfg_len_clamped = LEN_W'(MAX_LEN);
        end
    end

    // Compare only the low len bits of the shifted-in history against the pattern.
    always_comb begin
        len_mask = '0;
        for (int i = 0; i < int'(MAX_LEN); i++) begin
            len_mask[i] = (LEN_W'(i) < len_q);
        end
        hit = (((hist_n ^ pattern_q) & len_mask) == '0);
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= S_IDLE;
            hist_q  <= '0;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        if (!en) begin
            state_d = S_IDLE;
            hist_d  = '0;
            fill_d  = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    state_d = (len_eff == LEN_W'(1)) ? S_HUNT : S_FILL;
                    hist_d  = '0;
                    fill_d  = '0;
                end
                S_FILL: begin
                    if (accept) begin
                        hist_d = hist_n;
                        fill_d = fill_n;
                        if (fill_n >= len_q - LEN_W'(1)) begin
                            state_d = S_HUNT;
                        end
                    end
                end
                S_HUNT: begin
                    if (accept) begin
                        if (hit && !ovl_q) begin
                            // Non-overlapping: the matched bits cannot seed the next match.
                            hist_d  = '0;
                            fill_d  = '0;
                            state_d = (len_q == LEN_W'(1)) ? S_HUNT : S_FILL;
                        end else begin
                            hist_d = hist_n;
                            fill_d = fill_n;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    hist_d  = '0;
                    fill_d  = '0;
                end
            endcase
        end
    end

    always_comb begin
        y = 1'b0;
        if (accept && (state_q == S_HUNT) && hit) begin
            y = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            pattern_q <= DEF_PATTERN;
            len_q     <= LEN_W'(DEF_LEN);
            ovl_q     <= DEF_OVL;
        end else if (cfg_we) begin
            pattern_q <= cfg_pattern;
            len_q     <= cfg_len_clamped;
            ovl_q     <= cfg_overlap;
        end
    end

`ifdef MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Clear wins over a coincident match; count saturates at all-ones.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt_q <= '0;
        end else if (cnt_clr) begin
            cnt_q <= '0;
        end else if (y && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign match_cnt = cnt_q;
`else
    logic unused_cnt_clr;

    assign unused_cnt_clr = cnt_clr;
    assign match_cnt      = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: table of per-cycle vectors plus hand sequences for counter and reset.
module tb_seq_detector_param;

`ifdef MATCH_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_b;
    logic       en;
    logic       cfg_load;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       cfg_overlap;
    logic       x_vld;
    logic       x;
    logic       y;
    logic       cnt_clr;
    logic [1:0] match_cnt;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic       en;
        logic       ld;
        logic [7:0] pat;
        logic [3:0] len;
        logic       ovl;
        logic       vld;
        logic       x;
        logic       exp_y;
    } vec_t;

    vec_t tbl[$];

    seq_detector_param #(
        .MAX_LEN(8),
        .CNT_W  (2)
    ) dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .en         (en),
        .cfg_load   (cfg_load),
        .cfg_pattern(cfg_pattern),
        .cfg_len    (cfg_len),
        .cfg_overlap(cfg_overlap),
        .x_vld      (x_vld),
        .x          (x),
        .y          (y),
        .cnt_clr    (cnt_clr),
        .match_cnt  (match_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    function automatic void add(input logic en_v, input logic ld_v, input logic [7:0] pat_v,
                                input logic [3:0] len_v, input logic ovl_v, input logic vld_v,
                                input logic x_v, input logic ey_v);
        vec_t v;
        v.en = en_v; v.ld = ld_v; v.pat = pat_v; v.len = len_v; v.ovl = ovl_v;
        v.vld = vld_v; v.x = x_v; v.exp_y = ey_v;
        tbl.push_back(v);
    endfunction

    function automatic void addx(input logic en_v, input logic vld_v, input logic x_v, input logic ey_v);
        add(en_v, 1'b0, 8'h00, 4'd0, 1'b0, vld_v, x_v, ey_v);
    endfunction

    // Drive one cycle, check y mid-cycle, then advance past the next rising edge.
    task automatic step(input logic en_v, input logic vld_v, input logic x_v, input logic clr_v,
                        input logic ey, input string nm);
        en = en_v; x_vld = vld_v; x = x_v; cnt_clr = clr_v;
        @(negedge clk);
        chk(nm, 32'(y), 32'(ey));
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [6:0]  a_x, a_y;
        logic [6:0]  b_x, b_y;
        logic [10:0] c_x, c_y;
        logic [12:0] g_x, g_y;

        // Overlapping "11" with reset-default config
        addx(1'b0, 1'b1, 1'b1, 1'b0);
        addx(1'b1, 1'b0, 1'b0, 1'b0);
        a_x = 7'b0111011; a_y = 7'b0011001;
        for (int i = 6; i >= 0; i--) addx(1'b1, 1'b1, a_x[i], a_y[i]);
        addx(1'b0, 1'b0, 1'b0, 1'b0);
        // 1011, len 4, overlapping
        add(1'b0, 1'b1, 8'h0B, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        addx(1'b1, 1'b0, 1'b0, 1'b0);
        b_x = 7'b1011011; b_y = 7'b0001001;
        for (int i = 6; i >= 0; i--) addx(1'b1, 1'b1, b_x[i], b_y[i]);
        addx(1'b0, 1'b0, 1'b0, 1'b0);
        // 1011, len 4, non-overlapping
        add(1'b0, 1'b1, 8'h0B, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0);
        addx(1'b1, 1'b0, 1'b0, 1'b0);
        c_x = 11'b10110111011; c_y = 11'b00010000001;
        for (int i = 10; i >= 0; i--) addx(1'b1, 1'b1, c_x[i], c_y[i]);
        addx(1'b0, 1'b0, 1'b0, 1'b0);
        // Partial match lost on en drop; x_vld gaps inside a match
        addx(1'b1, 1'b0, 1'b0, 1'b0);
        addx(1'b1, 1'b1, 1'b1, 1'b0);
        addx(1'b1, 1'b1, 1'b0, 1'b0);
        addx(1'b1, 1'b1, 1'b1, 1'b0);
        addx(1'b0, 1'b1, 1'b1, 1'b0);
        addx(1'b1, 1'b1, 1'b1, 1'b0);
        addx(1'b1, 1'b1, 1'b1, 1'b0);
        addx(1'b1, 1'b1, 1'b0, 1'b0);
        addx(1'b1, 1'b0, 1'b1, 1'b0);
        addx(1'b1, 1'b1, 1'b1, 1'b0);
        addx(1'b1, 1'b0, 1'b1, 1'b0);
        addx(1'b1, 1'b1, 1'b1, 1'b1);
        addx(1'b0, 1'b0, 1'b0, 1'b0);
        // cfg_load while running is ignored
        addx(1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b1, 8'h00, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        addx(1'b1, 1'b1, 1'b1, 1'b0);
        addx(1'b1, 1'b1, 1'b0, 1'b0);
        addx(1'b1, 1'b1, 1'b1, 1'b0);
        addx(1'b1, 1'b1, 1'b1, 1'b1);
        addx(1'b0, 1'b0, 1'b0, 1'b0);
        // Load with en in the same IDLE cycle; len 0 clamps to 1
        add(1'b1, 1'b1, 8'h00, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        addx(1'b1, 1'b1, 1'b0, 1'b1);
        addx(1'b1, 1'b1, 1'b0, 1'b1);
        addx(1'b1, 1'b1, 1'b1, 1'b0);
        addx(1'b1, 1'b0, 1'b0, 1'b0);
        addx(1'b1, 1'b1, 1'b0, 1'b1);
        addx(1'b0, 1'b0, 1'b0, 1'b0);
        // len 15 clamps to 8; A5 overlaps itself on "101"
        add(1'b0, 1'b1, 8'hA5, 4'd15, 1'b1, 1'b0, 1'b0, 1'b0);
        addx(1'b1, 1'b0, 1'b0, 1'b0);
        g_x = 13'b1010010100101; g_y = 13'b0000000100001;
        for (int i = 12; i >= 0; i--) addx(1'b1, 1'b1, g_x[i], g_y[i]);

        rst_b = 1'b0; en = 1'b0; cfg_load = 1'b0; cfg_pattern = '0; cfg_len = '0;
        cfg_overlap = 1'b0; x_vld = 1'b1; x = 1'b1; cnt_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_y", 32'(y), 32'd0);
        chk("reset_cnt", 32'(match_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst_b = 1'b1;

        foreach (tbl[i]) begin
            en = tbl[i].en; cfg_load = tbl[i].ld; cfg_pattern = tbl[i].pat;
            cfg_len = tbl[i].len; cfg_overlap = tbl[i].ovl;
            x_vld = tbl[i].vld; x = tbl[i].x; cnt_clr = 1'b0;
            @(negedge clk);
            chk($sformatf("vec%0d_y", i), 32'(y), 32'(tbl[i].exp_y));
            @(posedge clk);
            #1;
        end
        cfg_load = 1'b0;

        // Counter: saturation, independence from en, clear priority
        chk("cnt_after_table", 32'(match_cnt), CNT_ON ? 32'd3 : 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "idle_y");
        chk("cnt_hold_en0", 32'(match_cnt), CNT_ON ? 32'd3 : 32'd0);
        cfg_load = 1'b1; cfg_pattern = 8'h01; cfg_len = 4'd1; cfg_overlap = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "load1_y");
        cfg_load = 1'b0;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "enter_y");
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, "clr_with_y");
        chk("cnt_clr_prio", 32'(match_cnt), 32'd0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, "m1_y");
        chk("cnt_one", 32'(match_cnt), CNT_ON ? 32'd1 : 32'd0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "nomatch_y");
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, $sformatf("m%0d_y", k + 2));
        chk("cnt_sat", 32'(match_cnt), CNT_ON ? 32'd3 : 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "clr_only_y");
        chk("cnt_clr", 32'(match_cnt), 32'd0);

        // Mid-stream reset: y suppressed, config and history back to defaults
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, "pre_rst_y");
        en = 1'b1; x_vld = 1'b1; x = 1'b1;
        rst_b = 1'b0;
        #2;
        chk("in_rst_y", 32'(y), 32'd0);
        chk("in_rst_cnt", 32'(match_cnt), 32'd0);
        @(posedge clk);
        #1;
        chk("in_rst_edge_y", 32'(y), 32'd0);
        rst_b = 1'b1;
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "post_rst_idle");
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "post_rst_fill");
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, "post_rst_def11");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
